// File: rtl/msg_sel_pkg.sv
// Shared types and constants for the message-select controller.
package msg_sel_pkg;

    localparam int unsigned MNS_W = 4;

    typedef enum logic [1:0] {
        StPowerup = 2'd0,
        StIdle    = 2'd1,
        StHold    = 2'd2
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stability debouncer and a
// one-cycle pulse on the debounced press (release gives no pulse).
module btn_debounce
    import msg_sel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            level_dly_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // The count only survives while every cycle disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    assign rise_o = level_q & ~level_dly_q;

endmodule

// File: rtl/msg_select_ctrl.sv
// Message selector for the LCD: power-up wait, next/prev buttons, post-change hold.
// Optional auto-advance in IDLE when MSG_SEL_AUTO_CYCLE_EN is defined.
module msg_select_ctrl
    import msg_sel_pkg::*;
#(
    parameter int unsigned NUM_MSG         = 2,
    parameter int unsigned POWERUP_CYCLES  = 2_500_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 15_000_000,
    parameter int unsigned AUTO_CYCLES     = 150_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_next_i,
    input  logic             btn_prev_i,
    output logic             ready_o,
    output logic [MNS_W-1:0] mns_o,
    output logic             change_o
);

    localparam int unsigned TmrMax = (POWERUP_CYCLES > HOLD_CYCLES) ? POWERUP_CYCLES : HOLD_CYCLES;
    localparam int unsigned TmrW   = cnt_width(TmrMax);
    localparam logic [TmrW-1:0]  PwrLast  = TmrW'(POWERUP_CYCLES - 1);
    localparam logic [TmrW-1:0]  HoldLast = TmrW'(HOLD_CYCLES - 1);
    localparam logic [MNS_W-1:0] MnsLast  = MNS_W'(NUM_MSG - 1);

    state_e           state_q, state_d;
    logic [TmrW-1:0]  timer_q, timer_d;
    logic [MNS_W-1:0] mns_q, mns_d;
    logic             ready_q, ready_d;
    logic             change_q, change_d;
    logic             next_rise, prev_rise;
    logic             go_next, go_prev;
    logic             auto_fire;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_next (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_next_i),
        .rise_o (next_rise)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_prev (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_prev_i),
        .rise_o (prev_rise)
    );

    // Simultaneous next and prev cancel each other.
    assign go_next = next_rise & ~prev_rise;
    assign go_prev = prev_rise & ~next_rise;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        mns_d   = mns_q;
        ready_d = ready_q;
        unique case (state_q)
            StPowerup: begin
                if (timer_q == PwrLast) begin
                    state_d = StIdle;
                    timer_d = '0;
                    ready_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StIdle: begin
                if (go_next || (auto_fire && !go_prev)) begin
                    mns_d   = (mns_q == MnsLast) ? '0 : mns_q + 1'b1;
                    state_d = StHold;
                    timer_d = '0;
                end else if (go_prev) begin
                    mns_d   = (mns_q == '0) ? MnsLast : mns_q - 1'b1;
                    state_d = StHold;
                    timer_d = '0;
                end
            end
            StHold: begin
                if (timer_q == HoldLast) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = StPowerup;
                timer_d = '0;
            end
        endcase
        // A single-message build wraps onto itself, so no pulse is produced.
        change_d = (mns_d != mns_q);
    end

`ifdef MSG_SEL_AUTO_CYCLE_EN
    localparam int unsigned AutoW = cnt_width(AUTO_CYCLES);
    localparam logic [AutoW-1:0] AutoLast = AutoW'(AUTO_CYCLES - 1);

    logic [AutoW-1:0] auto_q, auto_d;

    assign auto_fire = (state_q == StIdle) && (auto_q == AutoLast);

    // Counts idle cycles only; any step into HOLD starts the period over.
    always_comb begin
        auto_d = '0;
        if ((state_q == StIdle) && (state_d == StIdle)) begin
            auto_d = auto_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            auto_q <= '0;
        end else begin
            auto_q <= auto_d;
        end
    end
`else
    // AUTO_CYCLES has no role without auto-advance; the term folds to zero.
    assign auto_fire = 1'b0 & (AUTO_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StPowerup;
            timer_q  <= '0;
            mns_q    <= '0;
            ready_q  <= 1'b0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            mns_q    <= mns_d;
            ready_q  <= ready_d;
            change_q <= change_d;
        end
    end

    assign ready_o  = ready_q;
    assign mns_o    = mns_q;
    assign change_o = change_q;

endmodule

// File: tb/tb_msg_select_ctrl.sv
// Directed plus randomized bench for msg_select_ctrl with a timestamp-based press model.
module tb_msg_select_ctrl;

    localparam int N    = 3;
    localparam int PWR  = 10;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    // Raw press to mns_o update: 2 sync flops, DEB stable cycles, 1 cycle to act.
    localparam int LAT  = 2 + DEB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       ready_o;
    logic [3:0] mns_o;
    logic       change_o;

    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int fails = 0;
    int exp_mns = 0;
    bit exp_change = 1'b0;
    int ready_at = 1 << 30;
    int idle_from = 1 << 30;
    bit model_valid = 1'b0;
    int ev_cyc[$];
    int ev_dir[$];

    msg_select_ctrl #(
        .NUM_MSG         (N),
        .POWERUP_CYCLES  (PWR),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .AUTO_CYCLES     (5000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_next_i (btn_next),
        .btn_prev_i (btn_prev),
        .ready_o    (ready_o),
        .mns_o      (mns_o),
        .change_o   (change_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) passes++;
        else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, want);
        end
    endtask

    // One clock: advance the model, then compare all outputs.
    task automatic step();
        bit hit_n;
        bit hit_p;
        @(posedge clk);
        #1;
        cyc++;
        exp_change = 1'b0;
        if (reset) begin
            exp_mns     = 0;
            ready_at    = cyc + PWR;
            idle_from   = cyc + PWR + 1;
            model_valid = 1'b1;
            ev_cyc.delete();
            ev_dir.delete();
        end else begin
            hit_n = 1'b0;
            hit_p = 1'b0;
            for (int i = ev_cyc.size() - 1; i >= 0; i--) begin
                if (ev_cyc[i] == cyc) begin
                    if (ev_dir[i] > 0) hit_n = 1'b1;
                    else hit_p = 1'b1;
                    ev_cyc.delete(i);
                    ev_dir.delete(i);
                end
            end
            if ((hit_n != hit_p) && (cyc >= idle_from)) begin
                exp_mns    = hit_n ? (exp_mns + 1) % N : (exp_mns + N - 1) % N;
                exp_change = 1'b1;
                idle_from  = cyc + HOLD + 1;
            end
        end
        if (model_valid) begin
            chk("ready", 32'(ready_o), 32'(cyc >= ready_at));
            chk("mns", 32'(mns_o), exp_mns);
            chk("change", 32'(change_o), 32'(exp_change));
        end
    endtask

    // Presses shorter than the debounce window never produce an event.
    task automatic press(input bit n, input bit p, input int hold, input int gap);
        btn_next = n;
        btn_prev = p;
        if (hold >= DEB) begin
            if (n) begin ev_cyc.push_back(cyc + LAT); ev_dir.push_back(1);  end
            if (p) begin ev_cyc.push_back(cyc + LAT); ev_dir.push_back(-1); end
        end
        repeat (hold) step();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (gap) step();
    endtask

    initial begin
        int r;
        // Power-up after reset
        reset = 1'b1;
        repeat (3) step();
        chk("reset_mns", 32'(mns_o), 0);
        chk("reset_ready", 32'(ready_o), 0);
        reset = 1'b0;
        repeat (12) step();
        chk("powerup_ready", 32'(ready_o), 1);

        // Next presses with wrap
        press(1'b1, 1'b0, 6, 25);
        chk("next_1", 32'(mns_o), 1);
        press(1'b1, 1'b0, 6, 25);
        chk("next_2", 32'(mns_o), 2);
        press(1'b1, 1'b0, 6, 25);
        chk("next_wrap", 32'(mns_o), 0);

        // Prev wrap, then next during HOLD is dropped
        press(1'b0, 1'b1, 5, 0);
        press(1'b1, 1'b0, 6, 30);
        chk("prev_wrap_hold_drop", 32'(mns_o), 2);

        // Bounce shorter than the debounce window, then a clean hold
        repeat (3) press(1'b1, 1'b0, 3, 3);
        chk("bounce_none", 32'(mns_o), 2);
        press(1'b1, 1'b0, 6, 30);
        chk("bounce_then_hold", 32'(mns_o), 0);

        // Simultaneous edges ignored; a quick next proves FSM stayed in IDLE
        press(1'b1, 1'b1, 6, 5);
        chk("both_ignored", 32'(mns_o), 0);
        press(1'b1, 1'b0, 6, 30);
        chk("idle_after_both", 32'(mns_o), 1);

        // Reset in the middle of HOLD
        press(1'b1, 1'b0, 6, 0);
        repeat (4) step();
        chk("pre_reset_mns", 32'(mns_o), 2);
        reset = 1'b1;
        step();
        chk("midhold_reset_mns", 32'(mns_o), 0);
        chk("midhold_reset_ready", 32'(ready_o), 0);
        reset = 1'b0;
        repeat (9) step();
        chk("repowerup_wait", 32'(ready_o), 0);
        step();
        chk("repowerup_ready", 32'(ready_o), 1);
        repeat (2) step();

        // Randomized presses against the model
        for (int k = 0; k < 16; k++) begin
            r = $urandom_range(0, 4);
            press((r <= 1) || (r == 4), (r == 2) || (r == 3) || (r == 4),
                  $urandom_range(2, 9), $urandom_range(DEB, 30));
        end
        repeat (25) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
